// File: rtl/add_operand_sequencer_if.sv
// add_operand_sequencer_if: operand stream, result stream and external adder hookup for the sequencer
interface add_operand_sequencer_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             in_cin;
  logic [WIDTH-1:0] d_a;
  logic             en_a;
  logic [WIDTH-1:0] d_b;
  logic             en_b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [WIDTH:0]   res_data;
  logic             res_valid;
  logic             res_ready;
  modport master (
    output in_data, in_valid, in_cin, sum, cout, res_ready,
    input  in_ready, d_a, en_a, d_b, en_b, cin, res_data, res_valid
  );
  modport slave (
    input  in_data, in_valid, in_cin, sum, cout, res_ready,
    output in_ready, d_a, en_a, d_b, en_b, cin, res_data, res_valid
  );
endinterface

// File: rtl/add_operand_sequencer.sv
// add_operand_sequencer: loads A then B into an external adder's operand registers and captures {cout,sum}
// Optional: define ADD_SEQ_OVERFLOW_FLAG_EN to add output ovf, the signed overflow of A+B+cin held with the result.
module add_operand_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  add_operand_sequencer_if.slave bus
`ifdef ADD_SEQ_OVERFLOW_FLAG_EN
  ,
  output logic                   ovf
`endif
);
  typedef enum logic [2:0] {LOAD_A, LOAD_B, SETTLE, CAPTURE, HOLD} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_d_a;
  logic [WIDTH-1:0] r_d_b;
  logic             r_en_a;
  logic             r_en_b;
  logic             r_cin;
  logic             r_in_ready;
  logic [WIDTH:0]   r_res_data;
  logic             r_res_valid;
  logic             w_accept;
  assign w_accept      = bus.in_valid && r_in_ready;
  assign bus.in_ready  = r_in_ready;
  assign bus.d_a       = r_d_a;
  assign bus.d_b       = r_d_b;
  assign bus.en_a      = r_en_a;
  assign bus.en_b      = r_en_b;
  assign bus.cin       = r_cin;
  assign bus.res_data  = r_res_data;
  assign bus.res_valid = r_res_valid;
  // Sequencer FSM: accept A, accept B, let the operand registers settle, capture, hold until consumed
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= LOAD_A;
      r_d_a       <= '0;
      r_d_b       <= '0;
      r_en_a      <= 1'b0;
      r_en_b      <= 1'b0;
      r_cin       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_en_a <= 1'b0;
      r_en_b <= 1'b0;
      case (r_state)
        LOAD_A: if (w_accept) begin
          r_d_a   <= bus.in_data;
          r_en_a  <= 1'b1;
          r_state <= LOAD_B;
        end
        LOAD_B: if (w_accept) begin
          r_d_b      <= bus.in_data;
          r_en_b     <= 1'b1;
          r_cin      <= bus.in_cin;
          r_in_ready <= 1'b0;
          r_state    <= SETTLE;
        end
        SETTLE: r_state <= CAPTURE;
        CAPTURE: begin
          r_res_data  <= {bus.cout, bus.sum};
          r_res_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: if (bus.res_ready) begin
          r_res_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= LOAD_A;
        end
        default: begin
          r_in_ready <= 1'b1;
          r_state    <= LOAD_A;
        end
      endcase
    end
  end
`ifdef ADD_SEQ_OVERFLOW_FLAG_EN
  logic r_ovf;
  logic w_ovf;
  assign w_ovf = (r_d_a[WIDTH-1] == r_d_b[WIDTH-1]) && (bus.sum[WIDTH-1] != r_d_a[WIDTH-1]);
  assign ovf   = r_ovf;
  // Signed overflow flag, captured alongside the result and held with it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_ovf <= 1'b0;
    else if (r_state == CAPTURE) r_ovf <= w_ovf;
  end
`endif
endmodule

// File: tb/tb_add_operand_sequencer.sv
// tb_add_operand_sequencer: scoreboard bench with a behavioural operand-register/adder model
module tb_add_operand_sequencer;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  add_operand_sequencer_if #(.WIDTH(W)) bus ();
  logic [W-1:0] ext_a, ext_b;
`ifdef ADD_SEQ_OVERFLOW_FLAG_EN
  logic ovf;
`endif
  add_operand_sequencer #(.WIDTH(W)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
`ifdef ADD_SEQ_OVERFLOW_FLAG_EN
    ,
    .ovf (ovf)
`endif
  );
  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      ext_a <= '0;
      ext_b <= '0;
    end else begin
      if (bus.en_a) ext_a <= bus.d_a;
      if (bus.en_b) ext_b <= bus.d_b;
    end
  assign {bus.cout, bus.sum} = {1'b0, ext_a} + {1'b0, ext_b} + {{W{1'b0}}, bus.cin};
  int n_chk = 0;
  int n_err = 0;
  logic exp_cin = 1'b0;
  logic [W+1:0] sb[$];
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask
  task automatic send_a(input logic [W-1:0] a);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = a;
    bus.in_cin   = ~exp_cin;
    chk("rdy_a", 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = ~a;
    chk("en_a", 32'(bus.en_a), 1);
    chk("en_b_on_a", 32'(bus.en_b), 0);
    chk("d_a", 32'(bus.d_a), 32'(a));
    chk("cin_kept", 32'(bus.cin), 32'(exp_cin));
  endtask
  task automatic send_b(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input int gap, input int hold, input logic early);
    logic [W:0]   s;
    logic         o;
    logic [W+1:0] e;
    int           lat;
    repeat (gap) begin
      @(negedge clk);
      chk("gap_en", 32'({bus.en_a, bus.en_b}), 0);
      chk("gap_rdy", 32'(bus.in_ready), 1);
      chk("gap_d_a", 32'(bus.d_a), 32'(a));
    end
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    o = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    sb.push_back({o, s});
    bus.in_valid  = 1'b1;
    bus.in_data   = b;
    bus.in_cin    = c;
    bus.res_ready = early;
    chk("rdy_b", 32'(bus.in_ready), 1);
    @(negedge clk);
    exp_cin      = c;
    bus.in_valid = 1'b0;
    bus.in_cin   = ~c;
    chk("en_b", 32'(bus.en_b), 1);
    chk("en_a_on_b", 32'(bus.en_a), 0);
    chk("d_b", 32'(bus.d_b), 32'(b));
    chk("cin", 32'(bus.cin), 32'(c));
    chk("d_a_held", 32'(bus.d_a), 32'(a));
    chk("busy_rdy", 32'(bus.in_ready), 0);
    lat = 1;
    while (!bus.res_valid && lat < 10) begin
      @(negedge clk);
      lat++;
      chk("pulse_en", 32'({bus.en_a, bus.en_b}), 0);
    end
    chk("latency", 32'(lat), 3);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 1);
      e = '0;
    end else e = sb.pop_front();
    chk("res", 32'(bus.res_data), 32'(e[W:0]));
`ifdef ADD_SEQ_OVERFLOW_FLAG_EN
    chk("ovf", 32'(ovf), 32'(e[W+1]));
`endif
    if (!early) begin
      repeat (hold) begin
        @(negedge clk);
        chk("hold_v", 32'(bus.res_valid), 1);
        chk("hold_d", 32'(bus.res_data), 32'(e[W:0]));
        chk("hold_rdy", 32'(bus.in_ready), 0);
      end
      bus.res_ready = 1'b1;
    end
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("drop_v", 32'(bus.res_valid), 0);
    chk("idle_rdy", 32'(bus.in_ready), 1);
  endtask
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                    input int gap, input int hold, input logic early);
    send_a(a);
    send_b(a, b, c, gap, hold, early);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_cin    = 1'b0;
    bus.res_ready = 1'b0;
    @(negedge clk);
    chk("rst_d_a", 32'(bus.d_a), 0);
    chk("rst_d_b", 32'(bus.d_b), 0);
    chk("rst_en", 32'({bus.en_a, bus.en_b}), 0);
    chk("rst_cin", 32'(bus.cin), 0);
    chk("rst_res", 32'(bus.res_data), 0);
    chk("rst_v", 32'(bus.res_valid), 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_en", 32'({bus.en_a, bus.en_b}), 0);
    chk("idle_rdy0", 32'(bus.in_ready), 1);
    op(16'h1234, 16'h0FFF, 1'b0, 0, 0, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0, 0, 0, 1'b0);
    op(16'hFFFF, 16'hFFFF, 1'b1, 0, 1, 1'b0);
    op(16'h0101, 16'h0202, 1'b0, 0, 5, 1'b0);
    op(16'h00FF, 16'h0F00, 1'b1, 3, 0, 1'b0);
    op(16'h8000, 16'h8000, 1'b0, 1, 0, 1'b1);
    op(16'h7FFF, 16'h0001, 1'b0, 0, 0, 1'b0);
    op(16'h0001, 16'h0001, 1'b0, 0, 0, 1'b0);
    op(16'h7FFF, 16'h0000, 1'b1, 0, 2, 1'b0);
    send_a(16'hABCD);
    rstn = 1'b0;
    #1;
    chk("mid_d_a", 32'(bus.d_a), 0);
    chk("mid_d_b", 32'(bus.d_b), 0);
    chk("mid_en", 32'({bus.en_a, bus.en_b}), 0);
    chk("mid_cin", 32'(bus.cin), 0);
    chk("mid_res", 32'(bus.res_data), 0);
    chk("mid_v", 32'(bus.res_valid), 0);
    exp_cin = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_en", 32'({bus.en_a, bus.en_b}), 0);
    op(16'h0FFF, 16'h0001, 1'b1, 0, 0, 1'b0);
    for (int i = 0; i < 6; i++)
      op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
         int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/add_operand_sequencer.md
ADD_OPERAND_SEQUENCER -- requirements
Module: add_operand_sequencer

Interface
REQ-001 Parameter: WIDTH, 16, operand width; all operand and sum buses are WIDTH bits wide.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rstn  in  1  asynchronous active-low reset.
REQ-005 in_data  in  WIDTH  operand word stream: first word is A, second word is B.
REQ-006 in_valid  in  1  in_data is valid.
REQ-007 in_ready  out  1  sequencer accepts in_data this cycle.
REQ-008 in_cin  in  1  carry-in, sampled only with the B word.
REQ-009 d_a  out  WIDTH  operand-A register data.
REQ-010 en_a  out  1  operand-A register load enable.
REQ-011 d_b  out  WIDTH  operand-B register data.
REQ-012 en_b  out  1  operand-B register load enable.
REQ-013 cin  out  1  adder carry-in.
REQ-014 sum  in  WIDTH  adder sum, combinational from the registered operands.
REQ-015 cout  in  1  adder carry-out.
REQ-016 res_data  out  WIDTH+1  captured result {cout,sum}.
REQ-017 res_valid  out  1  res_data is valid.
REQ-018 res_ready  in  1  consumer accepts res_data.

Function
REQ-019 The FSM SHALL have states LOAD_A, LOAD_B, SETTLE, CAPTURE and HOLD; LOAD_A is the reset state.
REQ-020 in_ready SHALL be 1 in LOAD_A and LOAD_B, and 0 in all other states; a word is accepted on any edge where in_valid and in_ready are both 1.
REQ-021 LOAD_A accept: d_a<=in_data and en_a<=1 (registered); next state LOAD_B.
REQ-022 en_a and en_b SHALL each be single-cycle pulses; each is cleared on the edge after it is set.
REQ-023 LOAD_B accept: d_b<=in_data, en_b<=1 and cin<=in_cin; next state SETTLE.
REQ-024 SETTLE SHALL last one cycle, during which the external registers capture B; next state CAPTURE.
REQ-025 CAPTURE SHALL last one cycle, then: res_data<={cout,sum}, res_valid<=1; next state HOLD.
REQ-026 Latency SHALL be 3 edges from the B-accept edge to res_valid=1.
REQ-027 In HOLD, res_data and res_valid SHALL remain stable until res_ready=1.
REQ-028 On the HOLD edge where res_ready=1: res_valid<=0; next state LOAD_A.
REQ-029 d_a, d_b and cin SHALL hold their values between loads; they change only on an accept.
REQ-030 in_valid=0 in LOAD_A or LOAD_B SHALL leave the state unchanged and assert no enable.
REQ-031 Sums wrap modulo 2^WIDTH; the carry-out appears only in res_data[WIDTH].
REQ-032 res_ready asserted outside HOLD SHALL be ignored.

Reset
REQ-033 rstn=0 SHALL immediately force: state=LOAD_A; d_a=0, d_b=0; en_a=0, en_b=0; cin=0; res_data=0; res_valid=0.
REQ-034 Reset asserted mid-operation SHALL discard any partially loaded operands and any held result; no enable pulse follows reset release.

Configuration
REQ-035 Macro ADD_SEQ_OVERFLOW_FLAG_EN: when defined, add output port ovf (1 bit).
REQ-036 With the macro defined, ovf SHALL be captured in CAPTURE as the signed overflow of A+B+cin:
- operand MSBs equal, and
- sum MSB differs from them.
ovf SHALL be held with res_data and reset to 0.
REQ-037 With the macro undefined, the ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-038 A=0x1234, B=0x0FFF, cin=0 -> en_a and en_b each pulse 1 cycle; res_data=0x0_2233 3 edges after the B accept.
REQ-039 A=0xFFFF, B=0x0001, cin=0 -> res_data=0x1_0000; A=0xFFFF, B=0xFFFF, cin=1 -> res_data=0x1_FFFF.
REQ-040 res_ready held 0 for 5 cycles in HOLD -> res_valid and res_data stable; in_ready=0 throughout; then one handshake -> LOAD_A with in_ready=1.
REQ-041 rstn pulsed low after the A accept and before the B accept -> all outputs zero; a subsequent B-only word is treated as A (en_a pulses, not en_b).
REQ-042 in_valid gapped 3 cycles between A and B -> no extra enable pulses; result correct.
REQ-043 With ADD_SEQ_OVERFLOW_FLAG_EN: A=0x7FFF, B=0x0001, cin=0 -> res_data=0x0_8000 with ovf=1; A=0x0001, B=0x0001 -> ovf=0.
